// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: frame sequencer for the I/Q up-converter.
// Each frame is a BPSK preamble, LEN payload symbols from an upstream stream, then a zero tail.
module tx_frame_ctrl #(
  parameter int          PREAMBLE_LEN = 16,
  parameter int          TAIL_LEN     = 8,
  parameter logic [15:0] AMP          = 16'h4000,
  parameter int          LEN_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  input  logic [15:0]      s_a_i,
  input  logic [15:0]      s_b_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [15:0]      x_a_o,
  output logic [15:0]      x_b_o,
  output logic             x_valid_o,
  input  logic             x_ready_i
);

  localparam int PRE_W  = $clog2(PREAMBLE_LEN);
  localparam int TAIL_W = $clog2(TAIL_LEN);
  localparam int MAX_PT = (PRE_W > TAIL_W) ? PRE_W : TAIL_W;
  localparam int CNT_W  = (LEN_W > MAX_PT) ? LEN_W : MAX_PT;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);
  localparam logic [15:0]      NEG_AMP   = 16'h0000 - AMP;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_len_m1;
  logic [LEN_W-1:0] r_len;
  logic             r_done;
  logic             r_underrun;
  logic             w_xfer;
  logic             w_start;
  logic             w_pay_xfer;
  logic             w_tail_end;

  assign x_valid_o  = (r_state != S_IDLE);
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign underrun_o = r_underrun;

  assign w_xfer     = x_valid_o & x_ready_i;
  assign w_start    = (r_state == S_IDLE) & start_i;
  assign w_pay_xfer = (r_state == S_PAY) & w_xfer;
  assign w_tail_end = (r_state == S_TAIL) & w_xfer & (r_cnt == TAIL_LAST);
  assign w_len_m1   = CNT_W'(r_len) - CNT_W'(1);

  // Next-state and symbol counter; abort overrides the counter even when an xfer completes
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nx = S_PRE;
          w_cnt_nx   = {CNT_W{1'b0}};
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_PRE: begin
        if (abort_i) begin
          w_state_nx = S_TAIL;
          w_cnt_nx   = {CNT_W{1'b0}};
        end else if (w_xfer && (r_cnt == PRE_LAST)) begin
          w_state_nx = (r_len == {LEN_W{1'b0}}) ? S_TAIL : S_PAY;
          w_cnt_nx   = {CNT_W{1'b0}};
        end else if (w_xfer) begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_PAY: begin
        if (abort_i || (w_xfer && (r_cnt == w_len_m1))) begin
          w_state_nx = S_TAIL;
          w_cnt_nx   = {CNT_W{1'b0}};
        end else if (w_xfer) begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_TAIL: begin
        if (w_tail_end) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = {CNT_W{1'b0}};
        end else if (w_xfer) begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Symbol mux: payload is passed straight through so the up-converter never waits
  always_comb begin
    x_a_o     = 16'h0000;
    x_b_o     = 16'h0000;
    s_ready_o = 1'b0;
    case (r_state)
      S_PRE: begin
        x_a_o = r_cnt[0] ? NEG_AMP : AMP;
      end
      S_PAY: begin
        s_ready_o = x_ready_i;
        if (s_valid_i) begin
          x_a_o = s_a_i;
          x_b_o = s_b_i;
        end else begin
          x_a_o = 16'h0000;
          x_b_o = 16'h0000;
        end
      end
      default: begin
        x_a_o     = 16'h0000;
        x_b_o     = 16'h0000;
        s_ready_o = 1'b0;
      end
    endcase
  end

  // State registers, latched length, done pulse and sticky underrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_tail_end;
      if (w_start) begin
        r_len      <= len_i;
        r_underrun <= 1'b0;
      end else if (w_pay_xfer && !s_valid_i) begin
        r_underrun <= 1'b1;
      end else begin
        r_underrun <= r_underrun;
      end
    end
  end

endmodule
